// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side controller.
package fifo_reader_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fr_state_e;

  localparam int FR_SKID_DEPTH = 2;
  localparam int FR_PTR_W      = 3;

  // Skid occupancy counter spans 0..FR_SKID_DEPTH
  localparam int                   FR_CNT_W    = 2;
  localparam logic [FR_CNT_W-1:0]  FR_CNT_FULL = FR_CNT_W'(FR_SKID_DEPTH);
  localparam logic [FR_CNT_W-1:0]  FR_CNT_ONE  = FR_CNT_W'(1);

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer holding captured FIFO words in arrival order.
// Clear takes priority over a same-cycle write so flushed words never land.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DWIDTH = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [DWIDTH:0]     wr_data,
  input  logic                pop,
  input  logic                clear,
  output logic [FR_CNT_W-1:0] count,
  output logic [DWIDTH:0]     head
);

  logic [DWIDTH:0] mem [FR_SKID_DEPTH];
  logic            wr_ptr;
  logic            rd_ptr;
  logic            do_pop;
  logic            do_wr;

  assign do_pop = pop && (count != '0);
  assign do_wr  = wr_en && ((count != FR_CNT_FULL) || do_pop);
  assign head   = mem[rd_ptr];

  // Storage, pointers and occupancy update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FR_SKID_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   count <= count + FR_CNT_ONE;
        2'b01:   count <= count - FR_CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the 8-entry synchronous FIFO: issues pops,
// confirms them by watching the FIFO read pointer move, and presents the
// captured words on a valid/ready stream.
// Optional: define FIFO_READER_STATS_EN to add stat_pops / stat_retries.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DWIDTH = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                flush,
  input  logic                fifo_empty,
  input  logic [DWIDTH:0]     fifo_data,
  input  logic [FR_PTR_W-1:0] fifo_rptr,
  output logic                fifo_rd_en,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DWIDTH:0]     m_data,
  output logic                busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]         stat_pops,
  output logic [15:0]         stat_retries
`endif
);

  fr_state_e           state;
  fr_state_e           state_nxt;
  logic                inflight;
  logic [FR_PTR_W-1:0] rptr_q;
  logic [FR_CNT_W-1:0] count;
  logic                pop_out;
  logic                confirm;
  logic [2:0]          occ;
  logic                room;
  logic                buf_we;
  logic                buf_clear;

  assign pop_out = m_valid && m_ready;
  // A pointer that did not move means the FIFO serviced a write instead
  assign confirm = inflight && (fifo_rptr != rptr_q);
  // pop_out implies count >= 1, so this cannot underflow
  assign occ     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop_out};
  assign room    = (occ < 3'd2);
  assign m_valid = (count != '0);
  assign busy    = inflight || (count != '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state: FLUSH waits for any outstanding pop to resolve
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = FLUSH;
      FLUSH:   if (!inflight) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Outputs: issue rule, buffer write and buffer clear
  always_comb begin
    fifo_rd_en = 1'b0;
    buf_we     = 1'b0;
    buf_clear  = 1'b0;
    if (state == RUN) begin
      fifo_rd_en = enable && !fifo_empty && room && !flush;
      buf_we     = confirm && !flush;
      buf_clear  = flush;
    end
  end

  // Pop tracking: one request outstanding, with the pointer it started from
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
      rptr_q   <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_en) rptr_q <= fifo_rptr;
    end
  end

  fifo_reader_skid #(.DWIDTH(DWIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_we),
    .wr_data (fifo_data),
    .pop     (pop_out),
    .clear   (buf_clear),
    .count   (count),
    .head    (m_data)
  );

`ifdef FIFO_READER_STATS_EN
  logic retry;
  assign retry = inflight && (fifo_rptr == rptr_q);

  // Wrapping confirmed-pop and retry counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pops    <= '0;
      stat_retries <= '0;
    end else begin
      if (confirm) stat_pops    <= stat_pops + 16'd1;
      if (retry)   stat_retries <= stat_retries + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural 8-entry FIFO whose
// write wins over a same-cycle read (read pointer then stays put).
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       flush = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic [2:0] fifo_rptr;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       busy;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] stat_pops;
  logic [15:0] stat_retries;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic       wr_req = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] fmem [8];
  logic [2:0] f_wptr;
  logic [3:0] f_cnt;
  logic       f_pop;

  logic       mon_en = 1'b0;
  logic [7:0] rx_q [$];

  always #5 clk = ~clk;

  fifo_reader #(.DWIDTH(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rptr  (fifo_rptr),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .stat_pops    (stat_pops),
    .stat_retries (stat_retries)
`endif
  );

  // FIFO model: registered read data, write has priority over read
  assign fifo_empty = (f_cnt == 4'd0);
  assign f_pop      = fifo_rd_en && !wr_req && (f_cnt != 4'd0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wptr    <= 3'd0;
      fifo_rptr <= 3'd0;
      f_cnt     <= 4'd0;
      fifo_data <= 8'h00;
    end else begin
      if (wr_req) begin
        fmem[f_wptr] <= wr_data;
        f_wptr       <= f_wptr + 3'd1;
      end
      if (f_pop) begin
        fifo_data <= fmem[fifo_rptr];
        fifo_rptr <= fifo_rptr + 3'd1;
      end
      f_cnt <= f_cnt + {3'd0, wr_req} - {3'd0, f_pop};
    end
  end

  // Collects accepted words during the wrap test
  always @(negedge clk) begin
    if (mon_en && m_valid && m_ready) rx_q.push_back(m_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  initial begin
    logic [6:0] e_rd;
    logic [6:0] e_v;
    logic [5:0] e_rd2;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Streaming four words, consumer always ready
    for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
    enable  = 1'b1;
    m_ready = 1'b1;
    e_rd = 7'b0001111;
    e_v  = 7'b0111100;
    for (int i = 0; i < 7; i++) begin
      #1;
      check($sformatf("stream_rd_en_c%0d", i), fifo_rd_en, e_rd[i]);
      check($sformatf("stream_valid_c%0d", i), m_valid, e_v[i]);
      if (e_v[i]) check($sformatf("stream_data_c%0d", i), m_data, 8'h11 + 8'(i) - 8'd2);
      tick();
    end

    // Back-pressure: only two pops while the consumer stalls
    enable  = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h21 + 8'(i));
    enable = 1'b1;
    e_rd2  = 6'b000011;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("bp_rd_en_c%0d", i), fifo_rd_en, e_rd2[i]);
      tick();
    end
    #1;
    check("bp_hold_valid", m_valid, 1);
    check("bp_hold_data", m_data, 8'h21);
    check("bp_busy", busy, 1);
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("bp_drain_valid_c%0d", i), m_valid, (i < 5) ? 1 : 0);
      if (i < 5) check($sformatf("bp_drain_data_c%0d", i), m_data, 8'h21 + 8'(i));
      tick();
    end

    // Write collides with a pop: pointer stays, pop is reissued
    enable = 1'b0;
    push(8'h31);
    enable  = 1'b1;
    wr_req  = 1'b1;
    wr_data = 8'h32;
    #1;
    check("retry_rd_en_c0", fifo_rd_en, 1);
    tick();
    wr_req = 1'b0;
    #1;
    check("retry_rd_en_c1", fifo_rd_en, 1);
    check("retry_valid_c1", m_valid, 0);
    tick();
    #1;
    check("retry_valid_c2", m_valid, 0);
    tick();
    #1;
    check("retry_valid_c3", m_valid, 1);
    check("retry_data_c3", m_data, 8'h31);
    tick();
    #1;
    check("retry_data_c4", m_data, 8'h32);
    tick();
    #1;
    check("retry_valid_c5", m_valid, 0);
`ifdef FIFO_READER_STATS_EN
    check("stat_retries_1", stat_retries, 1);
    check("stat_pops_11", stat_pops, 11);
`endif

    // Flush with one word buffered and one pop in flight
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
    enable = 1'b1;
    #1;
    check("flush_rd_en_c0", fifo_rd_en, 1);
    tick();
    #1;
    check("flush_rd_en_c1", fifo_rd_en, 1);
    tick();
    flush = 1'b1;
    #1;
    check("flush_rd_en_gated", fifo_rd_en, 0);
    check("flush_head_data", m_data, 8'h41);
    tick();
    flush = 1'b0;
    #1;
    check("flush_valid_drop", m_valid, 0);
    check("flush_rd_en_c3", fifo_rd_en, 0);
    check("flush_busy_c3", busy, 0);
    tick();
    #1;
    check("flush_resume_rd_en", fifo_rd_en, 1);
    tick();
    tick();
    #1;
    check("flush_next_valid", m_valid, 1);
    check("flush_next_data", m_data, 8'h43);
    tick();
    #1;
    check("flush_next_data2", m_data, 8'h44);
    tick();
    #1;
    check("flush_end_valid", m_valid, 0);
`ifdef FIFO_READER_STATS_EN
    check("stat_pops_15", stat_pops, 15);
`endif

    // Ten words across a read-pointer wrap
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h51 + 8'(i));
    mon_en = 1'b1;
    enable = 1'b1;
    repeat (14) tick();
    enable = 1'b0;
    push(8'h59);
    push(8'h5A);
    enable = 1'b1;
    repeat (8) tick();
    mon_en = 1'b0;
    check("wrap_count", rx_q.size(), 10);
    for (int i = 0; i < rx_q.size() && i < 10; i++)
      check($sformatf("wrap_word_%0d", i), rx_q[i], 8'h51 + 8'(i));
    #1;
    check("wrap_idle_busy", busy, 0);

    // Asynchronous reset mid-stream, then resume
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h61 + 8'(i));
    enable = 1'b1;
    repeat (3) tick();
    #1;
    check("pre_rst_valid", m_valid, 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_data", m_data, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_rd_en", fifo_rd_en, 0);
`ifdef FIFO_READER_STATS_EN
    check("async_rst_stat_pops", stat_pops, 0);
`endif
    tick();
    rst = 1'b0;
    push(8'h71);
    #1;
    check("resume_rd_en", fifo_rd_en, 1);
    tick();
    tick();
    #1;
    check("resume_valid", m_valid, 1);
    check("resume_data", m_data, 8'h71);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
